dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Parametrised RV32 data-memory controller for the MEM stage. It accepts one load or store per handshake and applies RV32 size semantics: byte-lane write strobes on stores, sign or zero extension on loads. Misaligned, out-of-range and illegal-size accesses are flagged as errors. A configurable wait-state counter models slower memories, so the pipeline's stall logic can be exercised with latencies above one cycle.

## Interface
Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two ≥ 4
- WAIT_STATES, 0, extra cycles between accept and response; range 0..15
- ADDR_W, 32, byte-address width

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request this cycle
- req_wen  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, LSB-aligned
- rsp_valid  out  1  one-cycle pulse: response is valid
- rsp_rdata  out  32  load result, already extended; 0 for stores and errors
- rsp_err  out  1  access was faulted; qualified by rsp_valid

## Operation
- Accept occurs when req_valid and req_ready are both high at a rising edge. The controller registers wen, funct3, addr[1:0] and the error flag.
- State machine:
  - IDLE: req_ready=1. On accept, go to WAIT if WAIT_STATES>0, otherwise go to RESP.
  - WAIT: req_ready=0. Counter loads WAIT_STATES-1 on accept and decrements each cycle; at 0, go to RESP.
  - RESP: rsp_valid=1, req_ready=1. An accept in RESP is handled exactly as in IDLE (back-to-back). With no accept, go to IDLE.
- Error conditions, evaluated at accept:
  - funct3 ∈ {011, 110, 111}
  - H/HU with addr[0]=1
  - W with addr[1:0]≠0
  - addr ≥ DEPTH_WORDS*4
- A faulted access writes nothing and returns rsp_err=1, rsp_rdata=0. Its latency is identical to a good access.
- Word index is addr[log2(DEPTH_WORDS)+1:2].
- Store lanes: the write commits in the accept cycle.
  - SB: writes wdata[7:0] to lane addr[1:0].
  - SH: writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - SW: writes all four lanes. Other lanes are untouched.
- Load path: the word is read at the accept edge. The result is extracted using the registered addr[1:0].
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Stores return rsp_rdata=0, rsp_err=0.
- Memory array contents are not cleared by rst.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter 0.
- Latency: rsp_valid rises WAIT_STATES+1 cycles after the accept edge.
- Throughput:
  - WAIT_STATES=0: one access per cycle.
  - Otherwise: one access per WAIT_STATES+1 cycles.
- rsp_rdata and rsp_err hold their values only while rsp_valid=1. Otherwise they are 0.
- Read-after-write: a load accepted in the cycle after a store to the same word returns the new data.
- Reset mid-operation, asserted in WAIT or RESP:
  - Returns to IDLE immediately (asynchronous).
  - The pending response is dropped; rsp_valid is never raised for it.
  - A store accepted before reset remains committed.
- req_valid while req_ready=0 is ignored. The requester must hold the request until it is accepted.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → rsp_valid one cycle after accept, rdata 0xDEADBEEF, err 0.
- SB 0x80 @0x11, then:
  - LB @0x11 → 0xFFFFFF80
  - LBU @0x11 → 0x00000080
  - LW @0x10 → 0xDEAD80EF
- SH 0x8001 @0x12, then:
  - LH @0x12 → 0xFFFF8001
  - LHU @0x12 → 0x00008001
  - LH @0x13 → err=1, rdata 0
  - LW @0x10 confirms the word is unchanged by the faulted access.
- DEPTH_WORDS=1024: SW @0x1000 → err=1, no write (LW @0x0 unchanged); funct3=011 → err=1.
- WAIT_STATES=2: accept at cycle n → req_ready low n+1..n+2, rsp_valid at n+3. A back-to-back request issued in the RESP cycle is accepted at that edge.
- WAIT_STATES=3: assert rst during WAIT → outputs return to their reset values immediately, rsp_valid never pulses. A prior SW commit is still readable after reset.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between the MEM stage and the data-memory controller.
// Request side is valid/ready; the response is a single-cycle pulse that is never backpressured.
interface dmem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_wen, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// RV32 data-memory controller: byte-lane stores, sign/zero-extended loads, fault detection.
// Response WAIT_STATES+1 cycles after accept; req_ready drops only while counting wait states.
module dmem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 32
) (
    input  logic        clk,
    input  logic        rst,
    dmem_ctrl_if.slave  bus
);
    localparam int              IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH_WORDS) << 2;
    localparam logic [3:0]      WS_M1 = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t           r_state, w_next;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic             r_wen, r_err;
    logic [2:0]       r_f3;
    logic [1:0]       r_off;
    logic [31:0]      r_word;
    logic [31:0]      r_mem [DEPTH_WORDS];

    logic             w_accept, w_err;
    logic [IDX_W-1:0] w_idx;
    logic [3:0]       w_be;
    logic [31:0]      w_wd, w_ext;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;

    assign bus.req_ready = (r_state != S_WAIT);
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_idx         = bus.req_addr[IDX_W+1:2];

    always_comb begin
        w_err = 1'b0;
        case (bus.req_funct3)
            3'b000, 3'b100: w_err = 1'b0;
            3'b001, 3'b101: w_err = bus.req_addr[0];
            3'b010:         w_err = (bus.req_addr[1:0] != 2'b00);
            default:        w_err = 1'b1;
        endcase
        if ({1'b0, bus.req_addr} >= LIMIT) w_err = 1'b1;
    end

    // Store data is replicated across lanes so the strobe alone selects the target bytes.
    always_comb begin
        w_be = 4'b1111;
        w_wd = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                w_be = 4'b0001 << bus.req_addr[1:0];
                w_wd = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                w_be = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                w_wd = {2{bus.req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Array is deliberately outside reset: contents survive rst.
    always_ff @(posedge clk) begin
        if (w_accept && bus.req_wen && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
            end
        end
        if (w_accept) r_word <= r_mem[w_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_wen   <= 1'b0;
            r_err   <= 1'b0;
            r_f3    <= 3'b000;
            r_off   <= 2'b00;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_wen <= bus.req_wen;
                r_err <= w_err;
                r_f3  <= bus.req_funct3;
                r_off <= bus.req_addr[1:0];
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        case (r_state)
            S_WAIT: begin
                if (r_cnt == 4'd0) w_next = S_RESP;
                else               w_cnt_nxt = r_cnt - 4'd1;
            end
            S_RESP:  w_next = S_IDLE;
            default: ;
        endcase
        if (w_accept) begin
            if (WAIT_STATES > 0) begin
                w_next    = S_WAIT;
                w_cnt_nxt = WS_M1;
            end else begin
                w_next = S_RESP;
            end
        end
    end

    always_comb begin
        w_byte = r_word[{r_off, 3'b000} +: 8];
        w_half = r_off[1] ? r_word[31:16] : r_word[15:0];
        case (r_f3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = r_word;
        endcase
    end

    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_err   = bus.rsp_valid && r_err;
    assign bus.rsp_rdata = (bus.rsp_valid && !r_wen && !r_err) ? w_ext : 32'd0;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: three instances (0, 2 and 3 wait states) checked against a byte-array model.
module tb_dmem_ctrl;
    localparam int NI = 3;
    localparam int WS_TAB [NI] = '{0, 2, 3};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NI-1:0]       t_valid = '0;
    logic [NI-1:0]       t_wen   = '0;
    logic [NI-1:0][2:0]  t_f3    = '0;
    logic [NI-1:0][31:0] t_addr  = '0;
    logic [NI-1:0][31:0] t_wdata = '0;
    logic [NI-1:0]       t_ready, t_rvld, t_err;
    logic [NI-1:0][31:0] t_rdata;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_ctrl_if #(.ADDR_W(32)) bus ();
        assign bus.req_valid  = t_valid[g];
        assign bus.req_wen    = t_wen[g];
        assign bus.req_funct3 = t_f3[g];
        assign bus.req_addr   = t_addr[g];
        assign bus.req_wdata  = t_wdata[g];
        assign t_ready[g]     = bus.req_ready;
        assign t_rvld[g]      = bus.rsp_valid;
        assign t_rdata[g]     = bus.rsp_rdata;
        assign t_err[g]       = bus.rsp_err;

        dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(WS_TAB[g]), .ADDR_W(32)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
    end

    int n_chk  = 0;
    int n_fail = 0;
    int last_wait = 0;
    logic [7:0] mb [NI][4096];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory as a flat byte array; size/alignment rules applied arithmetically.
    task automatic ref_model(input int k, input logic wen, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] erd, output logic eer);
        int sz;
        logic [31:0] v;
        sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        eer = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || ((addr % sz) != 0) || (addr >= 32'd4096);
        erd = 32'd0;
        if (!eer) begin
            if (wen) begin
                for (int i = 0; i < sz; i++) mb[k][addr[11:0] + 12'(i)] = wdata[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < sz; i++) v = v | (32'(mb[k][addr[11:0] + 12'(i)]) << (8*i));
                if (!f3[2] && sz == 1 && v[7])  v = v | 32'hFFFF_FF00;
                if (!f3[2] && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
                erd = v;
            end
        end
    endtask

    // Called right after a falling edge; returns at the falling edge of the response cycle.
    task automatic do_op(input int k, input logic wen, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic er);
        int guard;
        int lat;
        logic [31:0] erd;
        logic eer;
        guard = 0;
        rd = 32'd0;
        er = 1'b0;
        while (!t_ready[k] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        last_wait = guard;
        if (!t_ready[k]) begin
            check("ready_timeout", 32'(t_ready[k]), 32'd1);
            return;
        end
        t_valid[k] = 1'b1;
        t_wen[k]   = wen;
        t_f3[k]    = f3;
        t_addr[k]  = addr;
        t_wdata[k] = wdata;
        ref_model(k, wen, f3, addr, wdata, erd, eer);
        @(posedge clk);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            t_valid[k] = 1'b0;
            lat++;
            if (t_rvld[k]) break;
            check("wait_ready_low", 32'(t_ready[k]), 32'd0);
            check("idle_rdata_zero", t_rdata[k], 32'd0);
        end
        check("latency", 32'(lat), 32'(WS_TAB[k] + 1));
        check("resp_ready_high", 32'(t_ready[k]), 32'd1);
        rd = t_rdata[k];
        er = t_err[k];
        check("rdata", rd, erd);
        check("err", 32'(er), 32'(eer));
    endtask

    // Accept a request, then reset while it sits in its wait states.
    task automatic abort_op(input int k, input logic wen, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] erd;
        logic eer;
        int pulses;
        check("abort_ready_pre", 32'(t_ready[k]), 32'd1);
        t_valid[k] = 1'b1;
        t_wen[k]   = wen;
        t_f3[k]    = f3;
        t_addr[k]  = addr;
        t_wdata[k] = wdata;
        ref_model(k, wen, f3, addr, wdata, erd, eer);
        @(posedge clk);
        @(negedge clk);
        t_valid[k] = 1'b0;
        check("abort_in_wait", 32'(t_ready[k]), 32'd0);
        rst = 1'b1;
        #1;
        check("abort_rst_ready", 32'(t_ready[k]), 32'd1);
        check("abort_rst_rvld", 32'(t_rvld[k]), 32'd0);
        check("abort_rst_rdata", t_rdata[k], 32'd0);
        check("abort_rst_err", 32'(t_err[k]), 32'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 1) rst = 1'b0;
            if (t_rvld[k]) pulses++;
        end
        check("abort_no_pulse", 32'(pulses), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd, w0;
        logic er;
        logic [2:0] leg [5];
        logic [2:0] ill [3];
        logic [2:0] f3;
        logic [31:0] addr;
        int r;
        leg = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        ill = '{3'd3, 3'd6, 3'd7};

        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check("reset_ready", 32'(t_ready[k]), 32'd1);
            check("reset_rvld", 32'(t_rvld[k]), 32'd0);
            check("reset_rdata", t_rdata[k], 32'd0);
            check("reset_err", 32'(t_err[k]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < NI; k++)
            for (int a = 0; a < 256; a += 4) do_op(k, 1'b1, 3'd2, 32'(a), $urandom, rd, er);

        // Size semantics on word 0x10, zero wait states.
        do_op(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, er);
        do_op(0, 1'b0, 3'd2, 32'h10, 32'd0, rd, er);  check("lw_10", rd, 32'hDEADBEEF);
        check("lw_10_err", 32'(er), 32'd0);
        do_op(0, 1'b1, 3'd0, 32'h11, 32'h80, rd, er);
        do_op(0, 1'b0, 3'd0, 32'h11, 32'd0, rd, er);  check("lb_11", rd, 32'hFFFFFF80);
        do_op(0, 1'b0, 3'd4, 32'h11, 32'd0, rd, er);  check("lbu_11", rd, 32'h00000080);
        do_op(0, 1'b0, 3'd2, 32'h10, 32'd0, rd, er);  check("lw_after_sb", rd, 32'hDEAD80EF);
        do_op(0, 1'b1, 3'd1, 32'h12, 32'h8001, rd, er);
        do_op(0, 1'b0, 3'd1, 32'h12, 32'd0, rd, er);  check("lh_12", rd, 32'hFFFF8001);
        do_op(0, 1'b0, 3'd5, 32'h12, 32'd0, rd, er);  check("lhu_12", rd, 32'h00008001);
        do_op(0, 1'b0, 3'd1, 32'h13, 32'd0, rd, er);  check("lh_13_err", 32'(er), 32'd1);
        check("lh_13_rdata", rd, 32'd0);
        do_op(0, 1'b0, 3'd2, 32'h10, 32'd0, rd, er);  check("lw_after_fault", rd, 32'h800180EF);

        do_op(0, 1'b0, 3'd2, 32'h0, 32'd0, w0, er);
        do_op(0, 1'b1, 3'd2, 32'h1000, 32'h55AA55AA, rd, er); check("sw_oob_err", 32'(er), 32'd1);
        do_op(0, 1'b0, 3'd2, 32'h0, 32'd0, rd, er);   check("lw_0_unchanged", rd, w0);
        do_op(0, 1'b0, 3'd3, 32'h0, 32'd0, rd, er);   check("f3_011_err", 32'(er), 32'd1);

        // Two wait states: second request is issued in the RESP cycle.
        do_op(1, 1'b1, 3'd2, 32'h40, 32'h0BADF00D, rd, er);
        do_op(1, 1'b0, 3'd2, 32'h40, 32'd0, rd, er);
        check("b2b_nowait", 32'(last_wait), 32'd0);
        check("b2b_lw_40", rd, 32'h0BADF00D);

        // Three wait states: reset during WAIT of a store and of a load.
        do_op(2, 1'b1, 3'd2, 32'h20, 32'h12345678, rd, er);
        abort_op(2, 1'b1, 3'd2, 32'h24, 32'hCAFEF00D);
        abort_op(2, 1'b0, 3'd2, 32'h20, 32'd0);
        do_op(2, 1'b0, 3'd2, 32'h20, 32'd0, rd, er);  check("post_rst_lw_20", rd, 32'h12345678);
        do_op(2, 1'b0, 3'd2, 32'h24, 32'd0, rd, er);  check("post_rst_lw_24", rd, 32'hCAFEF00D);

        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 200; n++) begin
                r  = $urandom_range(0, 15);
                f3 = (r < 13) ? leg[r % 5] : ill[r - 13];
                r  = $urandom_range(0, 15);
                if (r == 0)      addr = 32'($urandom_range(4096, 5000));
                else if (r == 1) addr = $urandom;
                else             addr = 32'($urandom_range(0, 255));
                do_op(k, 1'($urandom_range(0, 1)), f3, addr, $urandom, rd, er);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
